// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-RAM arbiter between the Controller
// (port 0) and the loader/debug master (port 1).
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_e;

    localparam int DMEM_ADDR_W    = 8;
    localparam int DMEM_DATA_W    = 16;
    localparam int DMEM_MAX_BURST = 4;

    // Counter must hold MAX_BURST itself, since it saturates there.
    function automatic int cnt_width(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    localparam int CNT_W = cnt_width(DMEM_MAX_BURST);

endpackage

// File: rtl/arb_rr_pick.sv
// Next-owner policy: round-robin on ties, burst-limited handover, and no
// IDLE bubble when the other port is already waiting.
module arb_rr_pick
    import dmem_arb_pkg::*;
#(
    parameter int MAX_BURST = DMEM_MAX_BURST,
    parameter int BEAT_W    = CNT_W
) (
    input  logic              req0,
    input  logic              req1,
    input  owner_e            owner,
    input  owner_e            last_owner,
    input  logic [BEAT_W-1:0] cnt,
    output owner_e            next_owner
);

    logic [BEAT_W:0] cnt_inc;
    logic            burst_done;

    always_comb begin
        // While an owner holds its request, the current cycle is a beat, so
        // cnt_inc is the count this beat produces.
        cnt_inc    = {1'b0, cnt} + (BEAT_W+1)'(1);
        burst_done = cnt_inc >= (BEAT_W+1)'(MAX_BURST);
        next_owner = owner;
        case (owner)
            OWN_P0: begin
                if (!req0)
                    next_owner = req1 ? OWN_P1 : OWN_IDLE;
                else if (burst_done && req1)
                    next_owner = OWN_P1;
            end
            OWN_P1: begin
                if (!req1)
                    next_owner = req0 ? OWN_P0 : OWN_IDLE;
                else if (burst_done && req0)
                    next_owner = OWN_P0;
            end
            default: begin
                if (req0 && req1)
                    next_owner = (last_owner == OWN_P0) ? OWN_P1 : OWN_P0;
                else if (req0)
                    next_owner = OWN_P0;
                else if (req1)
                    next_owner = OWN_P1;
                else
                    next_owner = OWN_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data RAM: registered grants, burst
// counting, and 1-cycle read-data return routed by a port tag.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = DMEM_ADDR_W,
    parameter int DATA_W    = DMEM_DATA_W,
    parameter int MAX_BURST = DMEM_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int BEAT_W = cnt_width(MAX_BURST);

    owner_e            owner;
    owner_e            next_owner;
    owner_e            last_owner;
    logic [BEAT_W-1:0] cnt;
    logic              beat;
    logic              rd_beat;
    logic              rd_pend_p1;
    logic              rd_tag_p1;

    function automatic logic [BEAT_W-1:0] sat_inc(input logic [BEAT_W-1:0] c);
        if (c >= BEAT_W'(MAX_BURST))
            return BEAT_W'(MAX_BURST);
        return c + BEAT_W'(1);
    endfunction

    arb_rr_pick #(
        .MAX_BURST (MAX_BURST),
        .BEAT_W    (BEAT_W)
    ) u_pick (
        .req0       (req0),
        .req1       (req1),
        .owner      (owner),
        .last_owner (last_owner),
        .cnt        (cnt),
        .next_owner (next_owner)
    );

    always_comb begin
        beat    = ((owner == OWN_P0) && req0) || ((owner == OWN_P1) && req1);
        rd_beat = ((owner == OWN_P0) && req0 && !we0) || ((owner == OWN_P1) && req1 && !we1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= OWN_IDLE;
            last_owner <= OWN_P1;
            cnt        <= '0;
            rd_pend_p1 <= 1'b0;
        end else begin
            owner <= next_owner;
            if (owner != OWN_IDLE && next_owner != owner)
                last_owner <= owner;
            if (owner == OWN_IDLE || next_owner != owner)
                cnt <= '0;
            else if (beat)
                cnt <= sat_inc(cnt);
            rd_pend_p1 <= rd_beat;
        end
    end

    // ---- read return stage: tag travels with the pending read ----
    always_ff @(posedge clk) begin
        rd_tag_p1 <= (owner == OWN_P1);
    end

    always_comb begin
        gnt0      = (owner == OWN_P0);
        gnt1      = (owner == OWN_P1);
        ram_addr  = '0;
        ram_wr    = 1'b0;
        ram_wdata = '0;
        case (owner)
            OWN_P0: begin
                ram_addr  = addr0;
                ram_wr    = we0 && req0;
                ram_wdata = wdata0;
            end
            OWN_P1: begin
                ram_addr  = addr1;
                ram_wr    = we1 && req1;
                ram_wdata = wdata1;
            end
            default: ;
        endcase
        rvalid0 = rd_pend_p1 && !rd_tag_p1;
        rvalid1 = rd_pend_p1 && rd_tag_p1;
        rdata   = ram_rdata;
    end

endmodule
